// File: rtl/bsg_lfsr_keystream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_lfsr_keystream_pkg
// Description : Shared types and constants for the LFSR keystream generator.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_lfsr_keystream_pkg;

  // Two-state handshake FSM: PRIME fills the output register, READY offers it
  typedef enum logic [0:0] {
    e_prime = 1'b0,
    e_ready = 1'b1
  } state_e;

  // Default Galois feedback mask for a 32-bit LFSR
  localparam logic [31:0] c_default_taps = 32'h80200003;

endpackage
`default_nettype wire

// File: rtl/bsg_lfsr_keystream_step.sv
`default_nettype none
// ============================================================================
// Module      : bsg_lfsr_keystream_step
// Description : Combinational width_p-step unroll of a Galois right-shift LFSR.
//               Step k supplies o_word[k] (LSB first); o_state is the state
//               after all width_p steps.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_lfsr_keystream_step #(
  parameter int                      width_p      = 1,
  parameter int                      lfsr_width_p = 2,
  parameter logic [lfsr_width_p-1:0] taps_p       = '1
) (
  input  logic [lfsr_width_p-1:0] i_state,
  output logic [width_p-1:0]      o_word,
  output logic [lfsr_width_p-1:0] o_state
);

  logic [lfsr_width_p-1:0] w_s;

  // Unrolled LFSR: emit s[0], then shift right and fold in taps when it was 1
  always_comb begin
    w_s    = i_state;
    o_word = '0;
    for (int k = 0; k < width_p; k++) begin
      o_word[k] = w_s[0];
      w_s       = (w_s >> 1) ^ (w_s[0] ? taps_p : '0);
    end
    o_state = w_s;
  end

endmodule
`default_nettype wire

// File: rtl/bsg_lfsr_keystream.sv
`default_nettype none
// ============================================================================
// Module      : bsg_lfsr_keystream
// Description : Keystream word source for bsg_xor. One width_p-bit word per
//               cycle from a Galois LFSR, valid/yumi handshake, consumed-word
//               counter and optional all-zero lockup repair.
// Config      : BSG_LFSR_KEYSTREAM_LOCKUP_FIX_EN - replace an all-zero state
//               with seed_p and pulse lockup_o (default: disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_lfsr_keystream
  import bsg_lfsr_keystream_pkg::*;
#(
  parameter                          width_p       = "inv",
  parameter int                      lfsr_width_p  = 32,
  parameter logic [lfsr_width_p-1:0] taps_p        = lfsr_width_p'(c_default_taps),
  parameter logic [lfsr_width_p-1:0] seed_p        = lfsr_width_p'(1),
  parameter int                      count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     seed_v_i,
  input  logic [lfsr_width_p-1:0]  seed_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic [count_width_p-1:0] count_o,
  output logic                     lockup_o
);

  // Elaboration-time parameter sanity
  if (lfsr_width_p < 2) begin : g_check_lfsr_width
    $error("bsg_lfsr_keystream: lfsr_width_p must be at least 2");
  end
  if (seed_p == '0) begin : g_check_seed
    $error("bsg_lfsr_keystream: seed_p must be nonzero");
  end

  state_e                   r_fsm;
  logic [lfsr_width_p-1:0]  r_state;
  logic [width_p-1:0]       r_data;
  logic [count_width_p-1:0] r_count;
  logic [width_p-1:0]       w_word;
  logic [lfsr_width_p-1:0]  w_next;
  logic                     w_repair;

  bsg_lfsr_keystream_step #(
    .width_p      (width_p),
    .lfsr_width_p (lfsr_width_p),
    .taps_p       (taps_p)
  ) u_step (
    .i_state (r_state),
    .o_word  (w_word),
    .o_state (w_next)
  );

`ifdef BSG_LFSR_KEYSTREAM_LOCKUP_FIX_EN
  logic r_lockup;

  // A zero state can only arrive via a seed load; it is caught while priming
  assign w_repair = (r_fsm == e_prime) && (r_state == '0);

  // One-cycle pulse on the edge that repairs the state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= w_repair && !seed_v_i;
    end
  end

  assign lockup_o = r_lockup;
`else
  assign w_repair = 1'b0;
  assign lockup_o = 1'b0;
`endif

  // Handshake FSM, LFSR state, output word and consumed-word counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fsm   <= e_prime;
      r_state <= seed_p;
      r_data  <= '0;
      r_count <= '0;
    end else if (seed_v_i) begin
      // Seed load wins over a same-cycle yumi, which is then not counted
      r_fsm   <= e_prime;
      r_state <= seed_i;
      r_count <= '0;
    end else begin
      case (r_fsm)
        e_prime: begin
          if (w_repair) begin
            // Spend one extra priming cycle restarting from the reset seed
            r_state <= seed_p;
          end else begin
            r_data  <= w_word;
            r_state <= w_next;
            r_fsm   <= e_ready;
          end
        end
        e_ready: begin
          if (yumi_i) begin
            r_data  <= w_word;
            r_state <= w_next;
            r_count <= r_count + 1'b1;
          end
        end
        default: r_fsm <= e_prime;
      endcase
    end
  end

  assign v_o     = (r_fsm == e_ready);
  assign data_o  = r_data;
  assign count_o = r_count;

`ifndef SYNTHESIS
  // Consumer protocol: yumi_i only while a word is offered
  a_yumi_only_when_valid : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o)
  ) else $error("bsg_lfsr_keystream: yumi_i asserted while v_o=0");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_lfsr_keystream.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_lfsr_keystream
// Description : Self-checking bench for bsg_lfsr_keystream (width 4, 8-bit
//               LFSR, taps 8'hB8, seed 8'h01, 2-bit counter). Expected words
//               come from an independent LFSR model via a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_lfsr_keystream;

  localparam int          c_w    = 4;
  localparam int          c_lw   = 8;
  localparam logic [7:0]  c_taps = 8'hB8;
  localparam logic [7:0]  c_seed = 8'h01;
  localparam int          c_cw   = 2;

  logic            clk_i     = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            seed_v_i  = 1'b0;
  logic [c_lw-1:0] seed_i    = '0;
  logic            yumi_i    = 1'b0;
  logic            v_o;
  logic [c_w-1:0]  data_o;
  logic [c_cw-1:0] count_o;
  logic            lockup_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [c_lw-1:0] m_state;
  logic [c_w-1:0]  q_exp[$];
  logic [c_cw-1:0] exp_cnt;

  bsg_lfsr_keystream #(
    .width_p       (c_w),
    .lfsr_width_p  (c_lw),
    .taps_p        (c_taps),
    .seed_p        (c_seed),
    .count_width_p (c_cw)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .seed_v_i  (seed_v_i),
    .seed_i    (seed_i),
    .v_o       (v_o),
    .data_o    (data_o),
    .yumi_i    (yumi_i),
    .count_o   (count_o),
    .lockup_o  (lockup_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Model: generate the next word bit by bit and push it to the scoreboard
  task automatic push_next();
    logic [c_w-1:0] w;
    w = '0;
    for (int k = 0; k < c_w; k++) begin
      w[k] = m_state[0];
      if (m_state[0]) m_state = (m_state >> 1) ^ c_taps;
      else            m_state = m_state >> 1;
    end
    q_exp.push_back(w);
  endtask

  task automatic model_restart(input logic [c_lw-1:0] s);
    q_exp.delete();
    m_state = s;
    exp_cnt = '0;
    push_next();
  endtask

  // Compare the offered word with the scoreboard head
  task automatic check_word(input string name);
    n_tests++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, data_o=%h", name, data_o);
    end else if (v_o !== 1'b1 || data_o !== q_exp[0]) begin
      n_fail++;
      $display("FAIL %s: got v_o=%b data_o=%h, expected v_o=1 data_o=%h", name, v_o, data_o, q_exp[0]);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (v_o !== 1'b0 || count_o !== 2'd0 || data_o !== 4'h0 || lockup_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b cnt=%0d data=%h lock=%b, expected 0 0 0 0", v_o, count_o, data_o, lockup_o);
    end
    @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    model_restart(c_seed);
    #1;
    n_tests++;
    if (v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL prime_cycle: got v_o=%b expected 0", v_o);
    end
    tick();
    n_tests++;
    if (data_o !== 4'h1) begin
      n_fail++;
      $display("FAIL first_word: got %h expected 1", data_o);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      check_word("hold_word");
      n_tests++;
      if (count_o !== 2'd0) begin
        n_fail++;
        $display("FAIL hold_count: got %0d expected 0", count_o);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    yumi_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_word("stream_word");
      n_tests++;
      if (count_o !== exp_cnt) begin
        n_fail++;
        $display("FAIL stream_count: got %0d expected %0d", count_o, exp_cnt);
      end
      if (i == 1) begin
        n_tests++;
        if (data_o !== 4'h7) begin
          n_fail++;
          $display("FAIL second_word: got %h expected 7", data_o);
        end
      end
      if (i == 4) begin
        n_tests++;
        if (count_o !== 2'd0) begin
          n_fail++;
          $display("FAIL count_wrap: got %0d expected 0", count_o);
        end
      end
      tick();
      void'(q_exp.pop_front());
      push_next();
      exp_cnt = exp_cnt + 1'b1;
    end
    yumi_i = 1'b0;
  endtask

  task automatic test_seed_priority();
    seed_v_i = 1'b1;
    seed_i   = 8'h01;
    yumi_i   = 1'b1;
    tick();
    seed_v_i = 1'b0;
    yumi_i   = 1'b0;
    model_restart(8'h01);
    n_tests++;
    if (v_o !== 1'b0 || count_o !== 2'd0) begin
      n_fail++;
      $display("FAIL seed_priority: got v=%b cnt=%0d expected v=0 cnt=0", v_o, count_o);
    end
    tick();
    check_word("seed_first_word");
  endtask

  task automatic test_async_reset();
    yumi_i = 1'b1;
    tick();
    tick();
    #2;
    reset_n_i = 1'b0;
    yumi_i    = 1'b0;
    #1;
    n_tests++;
    if (v_o !== 1'b0 || count_o !== 2'd0 || data_o !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b cnt=%0d data=%h expected 0 0 0", v_o, count_o, data_o);
    end
    tick();
    #2 reset_n_i = 1'b1;
    model_restart(c_seed);
    tick();
    check_word("restart_word");
  endtask

  task automatic test_lockup();
    seed_v_i = 1'b1;
    seed_i   = 8'h00;
    tick();
    seed_v_i = 1'b0;
    n_tests++;
    if (v_o !== 1'b0 || lockup_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_seed_prime: got v=%b lock=%b expected 0 0", v_o, lockup_o);
    end
`ifdef BSG_LFSR_KEYSTREAM_LOCKUP_FIX_EN
    tick();
    n_tests++;
    if (v_o !== 1'b0 || lockup_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lockup_pulse: got v=%b lock=%b expected 0 1", v_o, lockup_o);
    end
    model_restart(c_seed);
    tick();
`else
    model_restart(8'h00);
    tick();
`endif
    yumi_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_word("lockup_word");
      n_tests++;
      if (lockup_o !== 1'b0) begin
        n_fail++;
        $display("FAIL lockup_after: got %b expected 0", lockup_o);
      end
      tick();
      void'(q_exp.pop_front());
      push_next();
    end
    yumi_i = 1'b0;
  endtask

  initial begin
    #12;
    test_reset();
    test_hold();
    test_stream();
    test_seed_priority();
    test_async_reset();
    test_lockup();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
